// File: rtl/station_poll_scheduler.sv
// Polls up to MAX_STATIONS dropoff stations per sweep, sums their stored percentage
// with saturation, publishes the total and issues at most one round-robin train grant.
module station_poll_scheduler #(
   parameter int MAX_STATIONS = 16,
   parameter int INT          = 31,
   parameter int TIMEOUT      = 64,
   localparam int AW = (MAX_STATIONS > 1) ? $clog2(MAX_STATIONS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic [INT:0]  station_count,
   output logic          poll_valid,
   output logic [AW-1:0] poll_addr,
   input  logic          poll_ready,
   input  logic          resp_valid,
   input  logic [INT:0]  resp_percentage,
   input  logic          resp_wants_train,
   output logic [INT:0]  total_percentage_stored,
   output logic [INT:0]  number_of_stations,
   output logic          total_valid,
   output logic          station_fault,
   output logic [AW-1:0] fault_addr,
   output logic          grant_valid,
   output logic [AW-1:0] grant_station,
   input  logic          grant_ack
);

   localparam int CW = AW + 1;
   localparam int SW = INT + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, PUBLISH, GRANT} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           n_q, n_d, n_eff;
   logic [AW-1:0]           idx_q, idx_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic [INT:0]            acc_q, acc_d;
   logic [MAX_STATIONS-1:0] want_q, want_d;
   logic [AW-1:0]           rr_q, rr_d, rr_eff, rr_next;
   logic                    poll_valid_q, poll_valid_d;
   logic [AW-1:0]           poll_addr_q, poll_addr_d;
   logic [INT:0]            total_q, total_d;
   logic [INT:0]            number_q, number_d;
   logic                    total_valid_q, total_valid_d;
   logic                    station_fault_q, station_fault_d;
   logic [AW-1:0]           fault_addr_q, fault_addr_d;
   logic                    grant_valid_q, grant_valid_d;
   logic [AW-1:0]           grant_station_q, grant_station_d;
   logic                    gfound;
   logic [AW-1:0]           gsel;
   logic [SW:0]             sum;
   logic                    advance;

   always_comb begin
      if (station_count >= SW'(MAX_STATIONS)) n_eff = CW'(MAX_STATIONS);
      else                                    n_eff = CW'(station_count);
   end

   // Round-robin search: first wanted station at or after the pointer, modulo N.
   always_comb begin
      logic [CW-1:0] pos;
      logic [CW-1:0] nxt;
      pos     = '0;
      gfound  = 1'b0;
      gsel    = '0;
      rr_eff  = ({1'b0, rr_q} >= n_q) ? '0 : rr_q;
      for (int k = 0; k < MAX_STATIONS; k++) begin
         pos = {1'b0, rr_eff} + CW'(k);
         if (pos >= n_q) pos = pos - n_q;
         if (!gfound && (CW'(k) < n_q) && want_q[pos[AW-1:0]]) begin
            gfound = 1'b1;
            gsel   = pos[AW-1:0];
         end
      end
      nxt     = {1'b0, grant_station_q} + CW'(1);
      rr_next = (nxt >= n_q) ? '0 : nxt[AW-1:0];
   end

   always_comb begin
      state_d         = state_q;
      n_d             = n_q;
      idx_d           = idx_q;
      timer_d         = timer_q;
      acc_d           = acc_q;
      want_d          = want_q;
      rr_d            = rr_q;
      total_d         = total_q;
      number_d        = number_q;
      fault_addr_d    = fault_addr_q;
      grant_station_d = grant_station_q;
      total_valid_d   = 1'b0;
      station_fault_d = 1'b0;
      advance         = 1'b0;
      sum             = {1'b0, acc_q} + {1'b0, resp_percentage};

      case (state_q)
         IDLE: begin
            if (enable && (n_eff != '0)) begin
               n_d     = n_eff;
               acc_d   = '0;
               want_d  = '0;
               idx_d   = '0;
               timer_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (poll_ready) begin
               timer_d = '0;
               state_d = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            if (resp_valid) begin
               acc_d         = sum[SW] ? '1 : sum[INT:0];
               want_d[idx_q] = resp_wants_train;
               advance       = 1'b1;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               station_fault_d = 1'b1;
               fault_addr_d    = idx_q;
               want_d[idx_q]   = 1'b0;
               advance         = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         PUBLISH: begin
            total_valid_d = 1'b1;
            total_d       = acc_q;
            number_d      = SW'(n_q);
            if (gfound) begin
               grant_station_d = gsel;
               state_d         = GRANT;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (grant_ack) begin
               rr_d    = rr_next;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if ({1'b0, idx_q} == (n_q - CW'(1))) begin
            state_d = PUBLISH;
         end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ISSUE;
         end
      end

      // Handshake outputs are registered from the next state so they line up with it.
      poll_valid_d  = (state_d == ISSUE);
      poll_addr_d   = idx_d;
      grant_valid_d = (state_d == GRANT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         n_q             <= '0;
         idx_q           <= '0;
         timer_q         <= '0;
         acc_q           <= '0;
         want_q          <= '0;
         rr_q            <= '0;
         poll_valid_q    <= 1'b0;
         poll_addr_q     <= '0;
         total_q         <= '0;
         number_q        <= '0;
         total_valid_q   <= 1'b0;
         station_fault_q <= 1'b0;
         fault_addr_q    <= '0;
         grant_valid_q   <= 1'b0;
         grant_station_q <= '0;
      end else begin
         state_q         <= state_d;
         n_q             <= n_d;
         idx_q           <= idx_d;
         timer_q         <= timer_d;
         acc_q           <= acc_d;
         want_q          <= want_d;
         rr_q            <= rr_d;
         poll_valid_q    <= poll_valid_d;
         poll_addr_q     <= poll_addr_d;
         total_q         <= total_d;
         number_q        <= number_d;
         total_valid_q   <= total_valid_d;
         station_fault_q <= station_fault_d;
         fault_addr_q    <= fault_addr_d;
         grant_valid_q   <= grant_valid_d;
         grant_station_q <= grant_station_d;
      end
   end

   assign poll_valid              = poll_valid_q;
   assign poll_addr               = poll_addr_q;
   assign total_percentage_stored = total_q;
   assign number_of_stations      = number_q;
   assign total_valid             = total_valid_q;
   assign station_fault           = station_fault_q;
   assign fault_addr              = fault_addr_q;
   assign grant_valid             = grant_valid_q;
   assign grant_station           = grant_station_q;

endmodule

// File: tb/tb_station_poll_scheduler.sv
// Bench for station_poll_scheduler: acts as the station population and the dispatcher,
// predicting sweep totals and grants from a simple list-based model.
module tb_station_poll_scheduler;

   localparam int MAXS = 16;
   localparam int TO   = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [31:0] station_count = '0;
   logic        poll_valid;
   logic [3:0]  poll_addr;
   logic        poll_ready = 1'b0;
   logic        resp_valid = 1'b0;
   logic [31:0] resp_percentage = '0;
   logic        resp_wants_train = 1'b0;
   logic [31:0] total_percentage_stored;
   logic [31:0] number_of_stations;
   logic        total_valid;
   logic        station_fault;
   logic [3:0]  fault_addr;
   logic        grant_valid;
   logic [3:0]  grant_station;
   logic        grant_ack = 1'b0;

   station_poll_scheduler dut (
      .clk(clk), .rst(rst), .enable(enable), .station_count(station_count),
      .poll_valid(poll_valid), .poll_addr(poll_addr), .poll_ready(poll_ready),
      .resp_valid(resp_valid), .resp_percentage(resp_percentage),
      .resp_wants_train(resp_wants_train),
      .total_percentage_stored(total_percentage_stored),
      .number_of_stations(number_of_stations), .total_valid(total_valid),
      .station_fault(station_fault), .fault_addr(fault_addr),
      .grant_valid(grant_valid), .grant_station(grant_station), .grant_ack(grant_ack)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int          checks = 0;
   int          passes = 0;
   logic [31:0] exp_q[$];
   logic [31:0] s_arr[MAXS];
   bit          w_arr[MAXS];
   bit          silent_arr[MAXS];
   int          model_rr = 0;
   int          obs_grant = -1;
   int          seq27[5] = '{0, 1, 2, 3, 0};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_poll_valid"}, poll_valid, 0);
      chk({tag, "_poll_addr"}, poll_addr, 0);
      chk({tag, "_total"}, total_percentage_stored, 0);
      chk({tag, "_number"}, number_of_stations, 0);
      chk({tag, "_total_valid"}, total_valid, 0);
      chk({tag, "_station_fault"}, station_fault, 0);
      chk({tag, "_fault_addr"}, fault_addr, 0);
      chk({tag, "_grant_valid"}, grant_valid, 0);
      chk({tag, "_grant_station"}, grant_station, 0);
   endtask

   // reference model
   function automatic logic [31:0] model_total(input int n);
      longint sum = 0;
      for (int i = 0; i < n; i++) if (!silent_arr[i]) sum += longint'(s_arr[i]);
      if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
      return sum[31:0];
   endfunction

   function automatic int model_grant(input int n);
      int start = (model_rr >= n) ? 0 : model_rr;
      for (int k = 0; k < n; k++) begin
         int p = (start + k) % n;
         if (w_arr[p] && !silent_arr[p]) begin
            model_rr = (p + 1) % n;
            return p;
         end
      end
      return -1;
   endfunction

   task automatic clear_stations();
      for (int i = 0; i < MAXS; i++) begin
         s_arr[i] = '0;
         w_arr[i] = 1'b0;
         silent_arr[i] = 1'b0;
      end
   endtask

   // driver: one complete sweep (or a sweep cut short by reset at abort_idx)
   task automatic run_sweep(input int cnt, input int mid_cnt, input int abort_idx);
      int n = (cnt > MAXS) ? MAXS : cnt;
      int cyc;
      int d;
      int g;
      obs_grant = -1;
      station_count = cnt;
      enable = 1'b1;
      if (n == 0) begin
         repeat (4) step();
         chk("n0_no_poll", poll_valid, 0);
         chk("n0_no_total_valid", total_valid, 0);
         enable = 1'b0;
         return;
      end
      cyc = 0;
      while (!poll_valid && cyc < 10) begin
         step();
         cyc++;
      end
      chk("sweep_start", poll_valid, 1);
      enable = 1'b0;
      if (!poll_valid) return;
      station_count = mid_cnt;
      for (int i = 0; i < n; i++) begin
         chk("poll_valid", poll_valid, 1);
         chk("poll_addr", poll_addr, i);
         d = $urandom_range(0, 2);
         repeat (d) begin
            resp_valid = 1'($urandom_range(0, 1));
            resp_percentage = $urandom;
            step();
            chk("poll_hold_valid", poll_valid, 1);
            chk("poll_hold_addr", poll_addr, i);
         end
         poll_ready = 1'b1;
         resp_valid = 1'($urandom_range(0, 1));
         resp_percentage = $urandom;
         step();
         poll_ready = 1'b0;
         resp_valid = 1'b0;
         resp_percentage = '0;
         chk("poll_drop", poll_valid, 0);
         if (i == abort_idx) begin
            rst = 1'b1;
            #1;
            chk_zero("rst_mid_sweep");
            model_rr = 0;
            step();
            rst = 1'b0;
            step();
            chk("rst_then_idle", poll_valid, 0);
            return;
         end
         if (silent_arr[i]) begin
            cyc = 0;
            while (!station_fault && cyc < TO + 10) begin
               step();
               cyc++;
            end
            chk("fault_latency", cyc, TO);
            chk("fault_addr", fault_addr, i);
         end else begin
            d = $urandom_range(0, 3);
            repeat (d) step();
            resp_valid = 1'b1;
            resp_percentage = s_arr[i];
            resp_wants_train = w_arr[i];
            step();
            resp_valid = 1'b0;
            resp_wants_train = 1'b0;
            resp_percentage = '0;
         end
      end
      exp_q.push_back(model_total(n));
      g = model_grant(n);
      step();
      chk("total_valid", total_valid, 1);
      chk("fault_not_repeated", station_fault, 0);
      if (exp_q.size() > 0) chk("total", total_percentage_stored, exp_q.pop_front());
      chk("number_of_stations", number_of_stations, n);
      if (g >= 0) begin
         chk("grant_valid", grant_valid, 1);
         chk("grant_station", grant_station, g);
         obs_grant = int'(grant_station);
         d = $urandom_range(0, 2);
         repeat (d) begin
            step();
            chk("grant_hold", grant_valid, 1);
            chk("total_valid_pulse", total_valid, 0);
         end
         grant_ack = 1'b1;
         step();
         grant_ack = 1'b0;
         chk("grant_release", grant_valid, 0);
      end else begin
         chk("no_grant", grant_valid, 0);
      end
      step();
      chk("total_valid_once", total_valid, 0);
      chk("no_new_sweep", poll_valid, 0);
   endtask

   task automatic set_station(input int i, input logic [31:0] s, input bit w, input bit sil);
      s_arr[i] = s;
      w_arr[i] = w;
      silent_arr[i] = sil;
   endtask

   initial begin
      clear_stations();
      repeat (3) step();
      chk_zero("reset");
      rst = 1'b0;
      step();
      chk("post_reset_idle", poll_valid, 0);

      // three stations, nobody wants a train
      clear_stations();
      set_station(0, 40, 0, 0);
      set_station(1, 25, 0, 0);
      set_station(2, 10, 0, 0);
      run_sweep(3, 3, -1);
      chk("basic_total_75", total_percentage_stored, 75);
      chk("basic_number_3", number_of_stations, 3);
      chk("basic_no_grant", obs_grant, -1);

      // every station wants a train: grants rotate
      clear_stations();
      for (int i = 0; i < 4; i++) set_station(i, 32'(i + 1), 1, 0);
      for (int k = 0; k < 5; k++) begin
         run_sweep(4, 4, -1);
         chk("rr_grant_seq", obs_grant, seq27[k]);
      end

      // station 1 silent
      clear_stations();
      set_station(0, 17, 0, 0);
      set_station(1, 99, 1, 1);
      set_station(2, 23, 0, 0);
      run_sweep(3, 3, -1);
      chk("timeout_total", total_percentage_stored, 40);

      // station_count changes mid-sweep
      clear_stations();
      for (int i = 0; i < 5; i++) set_station(i, 32'(10 * (i + 1)), 0, 0);
      run_sweep(3, 5, -1);
      chk("count_change_old_g", number_of_stations, 3);
      chk("count_change_old_r", total_percentage_stored, 60);
      run_sweep(5, 5, -1);
      chk("count_change_new_g", number_of_stations, 5);
      chk("count_change_new_r", total_percentage_stored, 150);

      // saturation
      clear_stations();
      set_station(0, 32'h8000_0000, 0, 0);
      set_station(1, 32'h8000_0000, 0, 0);
      run_sweep(2, 2, -1);
      chk("saturate", total_percentage_stored, 32'hFFFF_FFFF);

      // reset during WAIT_RESP of idx 2, then a fresh sweep from address 0
      clear_stations();
      for (int i = 0; i < 4; i++) set_station(i, 32'(i + 5), 1, 0);
      run_sweep(4, 4, 2);
      run_sweep(4, 4, -1);
      chk("after_rst_grant0", obs_grant, 0);

      // randomized sweeps
      for (int r = 0; r < 10; r++) begin
         clear_stations();
         for (int i = 0; i < MAXS; i++)
            set_station(i, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 100)),
                        ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
         run_sweep($urandom_range(0, 20), $urandom_range(0, 20), -1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
